// File: rtl/route_request_queue.sv
// Request queue between the router mesh and the Q-learning route engine:
// buffers requests in a FIFO, issues them one at a time and holds each route until acked.
module route_request_queue #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [9:0]      req_info,
  output logic            req_full,
  input  logic            q_ready,
  output logic            q_req_en,
  output logic [9:0]      q_req_info,
  input  logic            q_done,
  input  logic [29:0]     q_route,
  output logic            rsp_valid,
  output logic [29:0]     rsp_route,
  output logic [4:0]      rsp_src,
  input  logic            rsp_ack,
  output logic            timeout,
  output logic [AW:0]     occupancy,
  output logic [7:0]      drop_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [AW:0] DEPTH_CNT    = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT      = (AW+1)'(1);
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [7:0]    wait_cnt;
  logic [AW:0]   occ_next;

  logic self_addr;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  // A self-addressed request needs no route, so it never enters the queue.
  assign self_addr = (req_info[9:5] == req_info[4:0]);
  assign fifo_full = (occupancy == DEPTH_CNT);
  assign pop       = (state == IDLE) && (occupancy != '0) && q_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign push      = req_valid && !self_addr && (!fifo_full || pop);
  assign drop      = req_valid && !self_addr && fifo_full && !pop;

  always_comb begin
    occ_next = occupancy;
    case ({push, pop})
      2'b10:   occ_next = occupancy + ONE_CNT;
      2'b01:   occ_next = occupancy - ONE_CNT;
      default: occ_next = occupancy;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      req_full   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= req_info;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occupancy <= occ_next;
      req_full  <= (occ_next == DEPTH_CNT);
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      q_req_en   <= 1'b0;
      q_req_info <= '0;
      rsp_valid  <= 1'b0;
      rsp_route  <= '0;
      rsp_src    <= '0;
      timeout    <= 1'b0;
    end else begin
      q_req_en <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            q_req_info <= mem[rd_ptr];
            q_req_en   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A route arriving on the last allowed cycle still counts.
          if (q_done) begin
            rsp_route <= q_route;
            rsp_src   <= q_req_info[9:5];
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (rsp_ack) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
